// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline sequencer.
//   reg_addr_t    - architectural register address (RegAddrBus width)
//   pctl_state_t  - sequencer states RUN / MC_BUSY / MEM_WAIT (2-bit)
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        PCTL_RUN      = 2'd0,
        PCTL_MC_BUSY  = 2'd1,
        PCTL_MEM_WAIT = 2'd2
    } pctl_state_t;

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the
// instruction in ID. The EX stage forwards only from EX/MEM and MEM/WB, so
// such a pair needs one bubble.
//   idex_mem_rd_i  - EX instruction is a load
//   idex_rd_i      - EX destination register
//   ifid_r1_i/r2_i - ID source registers
//   ifid_use_r*_i  - ID instruction actually reads that source
//   hit_o          - interlock required
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic      idex_mem_rd_i,
    input  reg_addr_t idex_rd_i,
    input  reg_addr_t ifid_r1_i,
    input  reg_addr_t ifid_r2_i,
    input  logic      ifid_use_r1_i,
    input  logic      ifid_use_r2_i,
    output logic      hit_o
);

    // x0 is hardwired zero, so a load targeting it never creates a hazard.
    assign hit_o = idex_mem_rd_i && (idex_rd_i != '0) &&
                   ((ifid_use_r1_i && (ifid_r1_i == idex_rd_i)) ||
                    (ifid_use_r2_i && (ifid_r2_i == idex_rd_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush sequencer for the 5-stage core.
// Inputs : EX/ID hazard fields, branch-taken, multi-cycle req/done,
//          data-memory req/ack.
// Outputs: per-register stall/flush (combinational), mc_start_o pulse,
//          sticky watchdog flag mc_err_o, saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_mem_rd_i,
    input  logic [REG_ADDR_W-1:0] idex_rd_i,
    input  logic [REG_ADDR_W-1:0] ifid_r1_i,
    input  logic [REG_ADDR_W-1:0] ifid_r2_i,
    input  logic                  ifid_use_r1_i,
    input  logic                  ifid_use_r2_i,
    input  logic                  br_jmp_en_i,
    input  logic                  mc_req_i,
    input  logic                  mc_done_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ack_i,
    output logic                  mc_start_o,
    output logic                  pc_stall_o,
    output logic                  ifid_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_stall_o,
    output logic                  idex_flush_o,
    output logic                  exmem_stall_o,
    output logic                  exmem_flush_o,
    output logic                  mc_err_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int unsigned WD_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    pctl_state_t      state_q, state_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q;

    logic lu_hit;
    logic memw;
    logic wd_expire;

    load_use_detect u_load_use_detect (
        .idex_mem_rd_i (idex_mem_rd_i),
        .idex_rd_i     (idex_rd_i),
        .ifid_r1_i     (ifid_r1_i),
        .ifid_r2_i     (ifid_r2_i),
        .ifid_use_r1_i (ifid_use_r1_i),
        .ifid_use_r2_i (ifid_use_r2_i),
        .hit_o         (lu_hit)
    );

    assign memw      = dmem_req_i && !dmem_ack_i;
    assign wd_expire = (wd_q == WD_LAST);

    // State register, watchdog, sticky error and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PCTL_RUN;
            wd_q        <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            if (pc_stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state. RUN and MEM_WAIT share one decision tree: a still-pending
    // memory access keeps (or enters) MEM_WAIT, and the ack cycle of MEM_WAIT
    // falls through to the ordinary RUN priorities.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_d   = err_q;
        case (state_q)
            PCTL_RUN, PCTL_MEM_WAIT: begin
                if (memw) begin
                    state_d = PCTL_MEM_WAIT;
                end else if (br_jmp_en_i) begin
                    state_d = PCTL_RUN;
                end else if (mc_req_i) begin
                    state_d = PCTL_MC_BUSY;
                    wd_d    = '0;
                end else begin
                    state_d = PCTL_RUN;
                end
            end
            PCTL_MC_BUSY: begin
                if (mc_done_i) begin
                    state_d = PCTL_RUN;
                end else if (wd_expire) begin
                    state_d = PCTL_RUN;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = PCTL_RUN;
        endcase
    end

    // Stall/flush outputs, all forced low while reset is asserted.
    always_comb begin
        mc_start_o    = 1'b0;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_stall_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_stall_o = 1'b0;
        exmem_flush_o = 1'b0;
        if (!rst) begin
            case (state_q)
                PCTL_RUN, PCTL_MEM_WAIT: begin
                    if (memw) begin
                        pc_stall_o    = 1'b1;
                        ifid_stall_o  = 1'b1;
                        idex_stall_o  = 1'b1;
                        exmem_stall_o = 1'b1;
                    end else if (br_jmp_en_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (mc_req_i) begin
                        mc_start_o    = 1'b1;
                        pc_stall_o    = 1'b1;
                        ifid_stall_o  = 1'b1;
                        idex_stall_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                    end else if (lu_hit) begin
                        pc_stall_o   = 1'b1;
                        ifid_stall_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end
                end
                PCTL_MC_BUSY: begin
                    // A watchdog expiry is handled exactly like a done cycle.
                    if (!mc_done_i && !wd_expire) begin
                        pc_stall_o    = 1'b1;
                        ifid_stall_o  = 1'b1;
                        idex_stall_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mc_err_o    = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core. It decides each cycle whether PC, IF/ID, ID/EX and EX/MEM advance, hold or take a bubble.
- Handles four cases:
  - load-use interlock: the EX stage forwards only from EX/MEM and MEM/WB, so a load result is one cycle late;
  - branch/jump flush on EX `br_jmp_en`;
  - multi-cycle EX operations (mul/div) via a start/done handshake;
  - data-memory wait states.
- Sits beside the pipeline registers; all stall and flush outputs are combinational from state plus inputs, so the freeze takes effect in the same cycle.

Parameters:
- MC_TIMEOUT, 64, cycles in MC_BUSY before the watchdog aborts.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- idex_mem_rd_i  in  1  instruction in EX is a load
- idex_rd_i  in  5  rd of instruction in EX
- ifid_r1_i  in  5  rs1 of instruction in ID
- ifid_r2_i  in  5  rs2 of instruction in ID
- ifid_use_r1_i  in  1  ID instruction reads rs1
- ifid_use_r2_i  in  1  ID instruction reads rs2
- br_jmp_en_i  in  1  EX branch taken / jump
- mc_req_i  in  1  EX instruction needs the multi-cycle unit
- mc_done_i  in  1  multi-cycle result valid this cycle
- dmem_req_i  in  1  MEM stage accessing data memory
- dmem_ack_i  in  1  data memory completes access this cycle
- mc_start_o  out  1  one-cycle start pulse to multi-cycle unit
- pc_stall_o  out  1  hold PC
- ifid_stall_o  out  1  hold IF/ID
- ifid_flush_o  out  1  load NOP into IF/ID
- idex_stall_o  out  1  hold ID/EX
- idex_flush_o  out  1  load NOP into ID/EX
- exmem_stall_o  out  1  hold EX/MEM
- exmem_flush_o  out  1  load NOP into EX/MEM
- mc_err_o  out  1  sticky watchdog flag
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1, saturating at all-ones

Behaviour:
- States: RUN, MC_BUSY, MEM_WAIT. On rst the state is RUN, mc_err_o=0 and stall_cnt_o=0. While rst=1 every stall/flush output and mc_start_o is 0.
- RUN resolves events in priority order; only the highest active event acts:
  1. Memory wait, `memw = dmem_req_i & !dmem_ack_i`:
     - assert pc, ifid, idex and exmem stalls; no flushes;
     - next state MEM_WAIT;
     - mc_req_i and br_jmp_en_i are ignored this cycle; the EX instruction is held and re-evaluated later.
  2. Branch/jump, `br_jmp_en_i`:
     - ifid_flush_o=1 and idex_flush_o=1; PC not stalled (it loads the target);
     - stay in RUN; any load-use hit is suppressed.
  3. Multi-cycle, `mc_req_i`:
     - mc_start_o=1; assert pc, ifid and idex stalls; exmem_flush_o=1;
     - next state MC_BUSY; watchdog counter cleared.
  4. Load-use:
     - hit = `idex_mem_rd_i & idex_rd_i!=0 & ((ifid_use_r1_i & ifid_r1_i==idex_rd_i) | (ifid_use_r2_i & ifid_r2_i==idex_rd_i))`;
     - on hit: pc_stall_o=1, ifid_stall_o=1, idex_flush_o=1 for exactly one cycle; stay in RUN;
     - the next cycle's forwarding from MEM/WB resolves the hazard.
- MEM_WAIT:
  - all four stalls stay asserted while `dmem_req_i & !dmem_ack_i`;
  - on dmem_ack_i, stalls drop in that same cycle and the state returns to RUN;
  - in the ack cycle, branch, multi-cycle and load-use are evaluated with the RUN rules; a memory wait is not.
- MC_BUSY:
  - pc, ifid and idex stalls stay asserted; exmem_flush_o=1 each cycle; mc_start_o=0; watchdog increments.
  - On mc_done_i: stalls and flush drop in that same cycle, the EX result advances, next state RUN.
  - In MC_BUSY, MEM holds a bubble, so dmem_req_i is don't-care.
  - Watchdog: if it reaches MC_TIMEOUT-1 without done:
    - mc_err_o is set (sticky until rst);
    - that cycle behaves as a done cycle; next state RUN.
  - mc_done_i and timeout in the same cycle: treat as a normal done; mc_err_o is not set.
- Reset mid-operation: any state goes to RUN on the next edge; mc_start_o is never reissued for an aborted operation.
- stall_cnt_o increments on every non-reset cycle with pc_stall_o=1 and holds at 2^CNT_W-1.

Decomposition:
- define.v gets:
  - state encodings PCTL_RUN, PCTL_MC_BUSY, PCTL_MEM_WAIT (2-bit);
  - the RegAddrBus width is reused from there.
- One combinational sub-module, `load_use_detect`: inputs are the EX and ID register fields; output is `hit`. It is instantiated once.
- The FSM, watchdog and stall counter stay in pipe_ctrl.

Test Plan:
- Load-use: idex_mem_rd_i=1, idex_rd_i=5, ifid_r2_i=5, ifid_use_r2_i=1 → one cycle of pc_stall/ifid_stall/idex_flush=1, then all 0; stall_cnt_o=1. Repeat with idex_rd_i=0 → no stall.
- Branch plus load-use in the same cycle: br_jmp_en_i=1 with the hit above → ifid_flush=idex_flush=1, pc_stall_o=0, one cycle only.
- Multi-cycle: mc_req_i=1 at cycle 0, mc_done_i=1 at cycle 4 →
  - mc_start_o high only at cycle 0;
  - stalls and exmem_flush high at cycles 0-3, low at cycle 4;
  - state RUN at cycle 5; stall_cnt_o=4.
- Memory wait: dmem_req_i=1 with ack held low 3 cycles, then ack; br_jmp_en_i=1 throughout →
  - 3 cycles with all four stalls high and no flush;
  - in the ack cycle, ifid_flush and idex_flush are high.
- Watchdog: MC_TIMEOUT=8, mc_req_i=1, mc_done_i never asserted → stalls drop after the 8th cycle counted from mc_start, mc_err_o=1 and stays 1 until rst.
- Reset mid-MC_BUSY: rst=1 for 1 cycle at cycle 2 of a multi-cycle op → all outputs 0 during rst; RUN, mc_err_o=0 and stall_cnt_o=0 afterward; no mc_start_o pulse.
